// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_pkg
// Brief    : Shared constants and entry layout for the instruction fetch queue.
// Revision : 1.0
// ============================================================================
package fetch_queue_pkg;

  localparam int          FQ_DEPTH    = 8;
  localparam logic [31:0] FQ_RESET_PC = 32'h0000_0000;

  // 64-bit entry: instr occupies [63:32], pc occupies [31:0].
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  function automatic fq_entry_t fq_pack(input logic [31:0] instr, input logic [31:0] pc);
    fq_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fq_ram.sv
`default_nettype none
// ============================================================================
// Module   : fq_ram
// Brief    : DEPTH x 64 register storage, two write ports, two async reads.
// Revision : 1.0
// ============================================================================
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  fq_entry_t       wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  fq_entry_t       wdata1,
  input  logic [AW-1:0]   raddr0,
  output fq_entry_t       rdata0,
  input  logic [AW-1:0]   raddr1,
  output fq_entry_t       rdata1
);

  fq_entry_t r_mem [DEPTH];

  // Contents need no reset: occupancy gating keeps stale entries invisible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we1 && (waddr1 == AW'(i))) begin
        r_mem[i] <= wdata1;
      end else if (we0 && (waddr0 == AW'(i))) begin
        r_mem[i] <= wdata0;
      end
    end
  end

  assign rdata0 = r_mem[raddr0];
  assign rdata1 = r_mem[raddr1];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Two-wide instruction fetch queue with redirect flush.
// Revision : 1.0
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rd,
  input  logic [31:0]              imem_rd2,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic [1:0]               deq_cnt,
  output logic [1:0]               out_valid,
  output logic [31:0]              out_instr0,
  output logic [31:0]              out_pc0,
  output logic [31:0]              out_instr1,
  output logic [31:0]              out_pc1,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [31:0]     r_pc;
  logic [c_aw-1:0] r_head;
  logic [c_aw-1:0] r_tail;
  logic [c_cw-1:0] r_count;

  logic [c_cw-1:0] w_free;
  logic [1:0]      w_deq;
  logic [1:0]      w_push;
  logic [1:0]      w_pop;
  logic [31:0]     w_pc4;
  logic            w_we0;
  logic            w_we1;
  fq_entry_t       w_rdata0;
  fq_entry_t       w_rdata1;
  logic            w_unused;

  assign w_unused = ^redirect_pc[1:0];

  always_comb begin
    w_free = c_cw'(DEPTH) - r_count;
    w_deq  = deq_cnt[1] ? 2'd2 : deq_cnt;
    if (w_free >= c_cw'(2)) begin
      w_push = 2'd2;
    end else if (w_free == c_cw'(1)) begin
      w_push = 2'd1;
    end else begin
      w_push = 2'd0;
    end
    // Pops are limited by what is actually stored; extra requests vanish.
    if (r_count < c_cw'(w_deq)) begin
      w_pop = r_count[1:0];
    end else begin
      w_pop = w_deq;
    end
  end

  assign w_pc4 = r_pc + 32'd4;
  assign w_we0 = rst_n && !redirect && (w_push != 2'd0);
  assign w_we1 = rst_n && !redirect && (w_push == 2'd2);

  fq_ram #(
    .DEPTH (DEPTH),
    .AW    (c_aw)
  ) u_ram (
    .clk    (clk),
    .we0    (w_we0),
    .waddr0 (r_tail),
    .wdata0 (fq_pack(imem_rd, r_pc)),
    .we1    (w_we1),
    .waddr1 (r_tail + c_aw'(1)),
    .wdata1 (fq_pack(imem_rd2, w_pc4)),
    .raddr0 (r_head),
    .rdata0 (w_rdata0),
    .raddr1 (r_head + c_aw'(1)),
    .rdata1 (w_rdata1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_pc    <= r_pc + {28'd0, w_push, 2'b00};
      r_head  <= r_head + c_aw'(w_pop);
      r_tail  <= r_tail + c_aw'(w_push);
      r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
    end
  end

  assign imem_addr    = r_pc;
  assign count        = r_count;
  assign out_valid[0] = (r_count != '0);
  assign out_valid[1] = (r_count >= c_cw'(2));
  assign out_instr0   = out_valid[0] ? w_rdata0.instr : 32'h0;
  assign out_pc0      = out_valid[0] ? w_rdata0.pc    : 32'h0;
  assign out_instr1   = out_valid[1] ? w_rdata1.instr : 32'h0;
  assign out_pc1      = out_valid[1] ? w_rdata1.pc    : 32'h0;

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 8, queue entries; power of two, minimum 4.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 imem_addr  output  32  fetch PC to instruction memory; bits [1:0] always 0.
REQ-006 imem_rd  input  32  word at imem_addr; combinational, same cycle.
REQ-007 imem_rd2  input  32  word at imem_addr+4; combinational, same cycle.
REQ-008 redirect  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-010 deq_cnt  input  2  entries decode consumes this cycle; 0, 1 or 2; 3 is treated as 2.
REQ-011 out_valid  output  2  bit0 = slot0 valid, bit1 = slot1 valid; bit1 is never set without bit0.
REQ-012 out_instr0 / out_pc0  output  32 each  oldest entry: instruction and its PC.
REQ-013 out_instr1 / out_pc1  output  32 each  second-oldest entry: instruction and its PC.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Each entry SHALL store {instr, pc}; head and tail pointers wrap modulo DEPTH.
REQ-016 free = DEPTH - count, sampled at the start of the cycle; same-cycle dequeues do not create space (no bypass).
REQ-017 Fetch: if free>=2, push {imem_rd, pc} then {imem_rd2, pc+4} and set pc += 8.
REQ-018 Fetch: if free==1, push {imem_rd, pc} only and set pc += 4.
REQ-019 Fetch: if free==0, push nothing and hold pc.
REQ-020 The pc register SHALL need no 8-byte alignment; any word-aligned pc fetches a pair.
REQ-021 Effective pop = min(deq_cnt clamped to 2, count); excess requests are silently ignored.
REQ-022 count_next = count + pushes - pops; push and pop in the same cycle are both applied.
REQ-023 Outputs are combinational from storage: out_valid[0] = (count>=1), out_valid[1] = (count>=2).
REQ-024 Invalid output slots SHALL drive instr=32'h0 and pc=32'h0.
REQ-025 Latency: a word presented on imem_rd at edge N appears on out_instr0 after edge N, if the queue was empty.
REQ-026 Redirect: on the edge where redirect=1, count, head and tail go to 0, pc becomes {redirect_pc[31:2],2'b00}, and no push or pop occurs.
REQ-027 After a redirect, the first target instruction is valid two edges later: fetch in cycle N+1, visible after edge N+1.
REQ-028 Redirect in the same cycle as a full queue or a nonzero deq_cnt SHALL still flush completely.
REQ-029 pc arithmetic is 32-bit modulo; wrap from 32'hFFFF_FFFC to 0 is legal.

Reset
REQ-030 While rst_n=0 at an edge: pc = RESET_PC, head = tail = count = 0, out_valid = 2'b00.
REQ-031 Reset SHALL override redirect and in-progress pushes/pops; contents are don't-care but never visible.
REQ-032 The first fetch occurs in the first cycle with rst_n=1; imem_addr = RESET_PC during that cycle.

Structure
REQ-033 A shared package/header SHALL hold FQ_DEPTH, RESET_PC and the 64-bit entry layout (instr in [63:32], pc in [31:0]).
REQ-034 Storage SHALL be one sub-module, fq_ram: DEPTH x 64 registers, two write ports, two asynchronous read ports.
REQ-035 Pointer, count and pc control SHALL stay in fetch_queue itself.

Verification
REQ-036 Reset release, memory word i = i, deq_cnt=0 -> after 4 edges count=8; out_pc0=0, out_pc1=4; imem_addr holds 32'h20.
REQ-037 Steady state, deq_cnt=2 every cycle, starting from empty -> count stays 2 after the first fetch; PCs stream 0,4,8,... with no gaps or duplicates.
REQ-038 Queue holds 7 entries, deq_cnt=0 -> exactly one push (pc+=4); count=8 and the next cycle pushes nothing.
REQ-039 redirect=1, redirect_pc=32'h0000_0103, queue full, deq_cnt=2 -> next edge count=0, imem_addr=32'h100; edge after that out_pc0=32'h100.
REQ-040 count=1, deq_cnt=2 -> one pop only; count = 1 - 1 + pushes; no underflow.
REQ-041 rst_n=0 asserted mid-stream together with redirect=1 -> out_valid=0 and imem_addr=RESET_PC on the next cycle.
